// File: rtl/pipeline_trace_monitor.sv
// rtl/pipeline_trace_monitor.sv - run-control FSM, retire/bubble counters and FWFT retirement trace FIFO
module pipeline_trace_monitor #(
    parameter int                   NUM_STAGES  = 5,
    parameter int                   XLEN        = 32,
    parameter int                   TRACE_DEPTH = 16,
    parameter int                   CNT_W       = 32,
    parameter int unsigned          MAX_CYCLES  = 1000,
    parameter logic [XLEN-1:0]      HALT_INST   = 32'h00000073
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           clear,
    input  logic [NUM_STAGES*XLEN-1:0]     stage_inst,
    input  logic [NUM_STAGES-1:0]          stage_valid,
    output logic                           running,
    output logic                           halted,
    output logic                           timeout,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               retired_count,
    output logic [CNT_W-1:0]               bubble_count,
    input  logic                           trace_rd_en,
    output logic [XLEN-1:0]                trace_rd_data,
    output logic                           trace_empty,
    output logic                           trace_full,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_overflow
);
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, bub_q, bub_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [XLEN-1:0]  mem_q [TRACE_DEPTH];

    logic [XLEN-1:0]  wb_word;
    logic             retire, halt, fifo_empty, fifo_full, pop, push, mem_we;

    // Only the WB stage drives behaviour; the other stages are accepted for port-width compatibility.
    logic unused_stages;
    assign unused_stages = ^{stage_inst[(NUM_STAGES-1)*XLEN-1:0], stage_valid[NUM_STAGES-2:0]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign wb_word    = stage_inst[(NUM_STAGES-1)*XLEN +: XLEN];
    assign retire     = (state_q == ST_RUN) && stage_valid[NUM_STAGES-1];
    assign halt       = retire && (wb_word == HALT_INST);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(TRACE_DEPTH));
    assign pop        = trace_rd_en && !fifo_empty;
    assign push       = retire && (!fifo_full || pop);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        ret_d    = ret_q;
        bub_d    = bub_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cyc_d   = '0;
                    ret_d   = '0;
                    bub_d   = '0;
                end
            end
            ST_RUN: begin
                cyc_d = sat_inc(cyc_q);
                if (retire) ret_d = sat_inc(ret_q);
                else        bub_d = sat_inc(bub_q);
                if (halt)                                 state_d = ST_HALTED;
                else if (cyc_q == CNT_W'(MAX_CYCLES - 1)) state_d = ST_TIMEOUT;
            end
            default: ;
        endcase

        if (push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
        if (retire && !push) ovf_d = 1'b1;

        if (clear) begin
            state_d  = ST_IDLE;
            cyc_d    = '0;
            ret_d    = '0;
            bub_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            mem_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            ret_q    <= '0;
            bub_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            ret_q    <= ret_d;
            bub_q    <= bub_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[wr_ptr_q] <= wb_word;
    end

    assign running        = (state_q == ST_RUN);
    assign halted         = (state_q == ST_HALTED);
    assign timeout        = (state_q == ST_TIMEOUT);
    assign cycle_count    = cyc_q;
    assign retired_count  = ret_q;
    assign bubble_count   = bub_q;
    assign trace_rd_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign trace_empty    = fifo_empty;
    assign trace_full     = fifo_full;
    assign trace_count    = cnt_q;
    assign trace_overflow = ovf_q;
endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// tb/tb_pipeline_trace_monitor.sv - directed self-checking bench for pipeline_trace_monitor
module tb_pipeline_trace_monitor;
    localparam int NS = 5;
    localparam int XL = 32;

    logic           clk = 1'b0;
    logic           reset, start, clear, trace_rd_en;
    logic [NS*XL-1:0] stage_inst;
    logic [NS-1:0]  stage_valid;
    logic           running, halted, timeout, trace_empty, trace_full, trace_overflow;
    logic [31:0]    cycle_count, retired_count, bubble_count, trace_rd_data;
    logic [2:0]     trace_count;

    int tests = 0;
    int fails = 0;

    pipeline_trace_monitor #(
        .NUM_STAGES(NS), .XLEN(XL), .TRACE_DEPTH(4), .CNT_W(32),
        .MAX_CYCLES(8), .HALT_INST(32'h00000073)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .stage_inst(stage_inst), .stage_valid(stage_valid),
        .running(running), .halted(halted), .timeout(timeout),
        .cycle_count(cycle_count), .retired_count(retired_count), .bubble_count(bubble_count),
        .trace_rd_en(trace_rd_en), .trace_rd_data(trace_rd_data), .trace_empty(trace_empty),
        .trace_full(trace_full), .trace_count(trace_count), .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_cycle(input logic v, input logic [31:0] w);
        stage_valid = {v, 4'b1011};
        stage_inst  = {w, 32'h00000013, 32'hDEAD0073, 32'h00000073, 32'h12345678};
        tick();
        stage_valid = '0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic enter_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pop_one();
        trace_rd_en = 1'b1;
        tick();
        trace_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests++;
        if ({running, halted, timeout, trace_empty, trace_full, trace_overflow} !== 6'b000100) begin
            fails++;
            $display("FAIL reset_flags got %b exp 000100", {running, halted, timeout, trace_empty, trace_full, trace_overflow});
        end
        tests++;
        if ({cycle_count, retired_count, bubble_count, trace_count, trace_rd_data} !== 131'd0) begin
            fails++;
            $display("FAIL reset_counters got %h %h %h %h %h exp all 0", cycle_count, retired_count, bubble_count, trace_count, trace_rd_data);
        end
    endtask

    task automatic test_halt_program();
        logic [31:0] exp_words [3];
        exp_words = '{32'h00500093, 32'h00A00113, 32'h00000073};
        enter_run();
        tests++;
        if ({running, cycle_count} !== {1'b1, 32'd0}) begin
            fails++;
            $display("FAIL run_entry got running=%b cycle=%0d exp 1 0", running, cycle_count);
        end
        wb_cycle(1'b1, 32'h00500093);
        wb_cycle(1'b1, 32'h00A00113);
        wb_cycle(1'b0, 32'h00000073);
        tests++;
        if ({running, halted} !== 2'b10) begin
            fails++;
            $display("FAIL halt_early got running=%b halted=%b exp 1 0", running, halted);
        end
        wb_cycle(1'b1, 32'h00000073);
        tests++;
        if ({running, halted, timeout} !== 3'b010) begin
            fails++;
            $display("FAIL halt_state got %b exp 010", {running, halted, timeout});
        end
        tests++;
        if ({cycle_count, retired_count, bubble_count} !== {32'd4, 32'd3, 32'd1}) begin
            fails++;
            $display("FAIL halt_counts got %0d %0d %0d exp 4 3 1", cycle_count, retired_count, bubble_count);
        end
        wb_cycle(1'b1, 32'h00000093);
        tests++;
        if ({cycle_count, retired_count, trace_count} !== {32'd4, 32'd3, 3'd3}) begin
            fails++;
            $display("FAIL halt_frozen got %0d %0d %0d exp 4 3 3", cycle_count, retired_count, trace_count);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (trace_rd_data !== exp_words[i]) begin
                fails++;
                $display("FAIL halt_pop%0d got %h exp %h", i, trace_rd_data, exp_words[i]);
            end
            pop_one();
        end
        tests++;
        if ({trace_empty, trace_count, trace_rd_data} !== {1'b1, 3'd0, 32'd0}) begin
            fails++;
            $display("FAIL halt_drained got %b %0d %h exp 1 0 0", trace_empty, trace_count, trace_rd_data);
        end
        pop_one();
        tests++;
        if ({trace_empty, trace_count} !== {1'b1, 3'd0}) begin
            fails++;
            $display("FAIL pop_empty got %b %0d exp 1 0", trace_empty, trace_count);
        end
    endtask

    task automatic test_timeout();
        pulse_clear();
        enter_run();
        for (int i = 0; i < 7; i++) wb_cycle(1'b0, 32'h0);
        tests++;
        if ({running, timeout, cycle_count} !== {1'b1, 1'b0, 32'd7}) begin
            fails++;
            $display("FAIL timeout_early got %b %b %0d exp 1 0 7", running, timeout, cycle_count);
        end
        wb_cycle(1'b0, 32'h0);
        tests++;
        if ({running, halted, timeout} !== 3'b001) begin
            fails++;
            $display("FAIL timeout_state got %b exp 001", {running, halted, timeout});
        end
        tests++;
        if ({cycle_count, retired_count, bubble_count} !== {32'd8, 32'd0, 32'd8}) begin
            fails++;
            $display("FAIL timeout_counts got %0d %0d %0d exp 8 0 8", cycle_count, retired_count, bubble_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if ({timeout, cycle_count} !== {1'b1, 32'd8}) begin
            fails++;
            $display("FAIL timeout_sticky got %b %0d exp 1 8", timeout, cycle_count);
        end
    endtask

    task automatic test_overflow();
        pulse_clear();
        enter_run();
        for (int i = 0; i < 6; i++) wb_cycle(1'b1, 32'hA000_0000 + i);
        tests++;
        if ({trace_full, trace_count, trace_overflow} !== {1'b1, 3'd4, 1'b1}) begin
            fails++;
            $display("FAIL ovf_state got full=%b count=%0d ovf=%b exp 1 4 1", trace_full, trace_count, trace_overflow);
        end
        tests++;
        if (retired_count !== 32'd6) begin
            fails++;
            $display("FAIL ovf_retired got %0d exp 6", retired_count);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (trace_rd_data !== 32'hA000_0000 + i) begin
                fails++;
                $display("FAIL ovf_pop%0d got %h exp %h", i, trace_rd_data, 32'hA000_0000 + i);
            end
            pop_one();
        end
        tests++;
        if ({trace_empty, trace_overflow} !== 2'b11) begin
            fails++;
            $display("FAIL ovf_drained got empty=%b ovf=%b exp 1 1", trace_empty, trace_overflow);
        end
    endtask

    task automatic test_back_to_back();
        pulse_clear();
        tests++;
        if (trace_overflow !== 1'b0) begin
            fails++;
            $display("FAIL clear_ovf got %b exp 0", trace_overflow);
        end
        enter_run();
        for (int i = 0; i < 4; i++) wb_cycle(1'b1, 32'hB000_0000 + i);
        tests++;
        if ({trace_full, trace_count, trace_overflow} !== {1'b1, 3'd4, 1'b0}) begin
            fails++;
            $display("FAIL b2b_full got %b %0d %b exp 1 4 0", trace_full, trace_count, trace_overflow);
        end
        trace_rd_en = 1'b1;
        wb_cycle(1'b1, 32'hB000_0004);
        trace_rd_en = 1'b0;
        tests++;
        if ({trace_count, trace_overflow, trace_rd_data} !== {3'd4, 1'b0, 32'hB000_0001}) begin
            fails++;
            $display("FAIL b2b_pushpop got %0d %b %h exp 4 0 b0000001", trace_count, trace_overflow, trace_rd_data);
        end
        for (int i = 1; i < 5; i++) begin
            tests++;
            if (trace_rd_data !== 32'hB000_0000 + i) begin
                fails++;
                $display("FAIL b2b_pop%0d got %h exp %h", i, trace_rd_data, 32'hB000_0000 + i);
            end
            pop_one();
        end
        tests++;
        if (trace_empty !== 1'b1) begin
            fails++;
            $display("FAIL b2b_empty got %b exp 1", trace_empty);
        end
    endtask

    task automatic test_halt_at_limit();
        pulse_clear();
        enter_run();
        for (int i = 0; i < 7; i++) wb_cycle(1'b0, 32'h0);
        wb_cycle(1'b1, 32'h00000073);
        tests++;
        if ({halted, timeout, running} !== 3'b100) begin
            fails++;
            $display("FAIL limit_state got halted=%b timeout=%b running=%b exp 1 0 0", halted, timeout, running);
        end
        tests++;
        if ({cycle_count, retired_count, bubble_count, trace_rd_data} !== {32'd8, 32'd1, 32'd7, 32'h00000073}) begin
            fails++;
            $display("FAIL limit_counts got %0d %0d %0d %h exp 8 1 7 00000073", cycle_count, retired_count, bubble_count, trace_rd_data);
        end
    endtask

    task automatic test_reset_clear_midrun();
        pulse_clear();
        enter_run();
        for (int i = 0; i < 3; i++) wb_cycle(1'b1, 32'hC000_0000 + i);
        tests++;
        if (trace_count !== 3'd3) begin
            fails++;
            $display("FAIL mid_fill got %0d exp 3", trace_count);
        end
        reset = 1'b1;
        wb_cycle(1'b1, 32'hC000_0003);
        reset = 1'b0;
        tests++;
        if ({running, cycle_count, retired_count, bubble_count, trace_empty, trace_count} !== {1'b0, 96'd0, 1'b1, 3'd0}) begin
            fails++;
            $display("FAIL mid_reset got run=%b %0d %0d %0d empty=%b cnt=%0d exp 0 0 0 0 1 0", running, cycle_count, retired_count, bubble_count, trace_empty, trace_count);
        end
        enter_run();
        wb_cycle(1'b1, 32'hC000_0010);
        wb_cycle(1'b1, 32'h00000073);
        tests++;
        if ({halted, trace_count, retired_count} !== {1'b1, 3'd2, 32'd2}) begin
            fails++;
            $display("FAIL pre_clear got %b %0d %0d exp 1 2 2", halted, trace_count, retired_count);
        end
        pulse_clear();
        tests++;
        if ({running, halted, timeout, cycle_count, retired_count, bubble_count, trace_empty, trace_overflow} !== {3'b000, 96'd0, 2'b10}) begin
            fails++;
            $display("FAIL clear_halted got %b %0d %0d %0d empty=%b ovf=%b exp 000 0 0 0 1 0", {running, halted, timeout}, cycle_count, retired_count, bubble_count, trace_empty, trace_overflow);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; clear = 1'b0; trace_rd_en = 1'b0;
        stage_inst = '0; stage_valid = '0;
        test_reset();
        test_halt_program();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_halt_at_limit();
        test_reset_clear_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
